// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for the CPU register file.
// On a start pulse it walks registers 0..NREGS-1 through a single read port and
// streams a byte frame over valid/ready: header, 4 little-endian bytes per
// register, then an XOR checksum of the register bytes (header excluded).
module regfile_dump #(
  parameter int          NREGS  = 32,
  parameter int          ADDR_W = 5,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_BYTE = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        byte_sel;
  logic [7:0]        csum;
  logic [31:0]       word;
  logic [1:0]        next_sel;
  logic [7:0]        next_byte;
  logic              accept;

  assign accept   = out_valid && out_ready;
  assign next_sel = byte_sel + 2'd1;

  // Select the byte of the latched word that follows the one currently on out_data.
  always_comb begin
    next_byte = word[7:0];
    case (next_sel)
      2'd0:    next_byte = word[7:0];
      2'd1:    next_byte = word[15:8];
      2'd2:    next_byte = word[23:16];
      default: next_byte = word[31:24];
    endcase
  end

  // Frame sequencer: out_data/out_valid are loaded one cycle ahead so they are
  // registered outputs, and everything holds while a byte waits for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      byte_sel  <= 2'd0;
      csum      <= 8'h00;
      word      <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_HDR;
            busy      <= 1'b1;
            idx       <= '0;
            csum      <= 8'h00;
            out_valid <= 1'b1;
            out_data  <= HEADER;
          end
        end
        S_HDR: begin
          if (accept) begin
            state     <= S_LOAD;
            out_valid <= 1'b0;
            rd_addr   <= idx;
          end
        end
        S_LOAD: begin
          word      <= rd_data;
          byte_sel  <= 2'd0;
          out_data  <= rd_data[7:0];
          out_valid <= 1'b1;
          state     <= S_BYTE;
        end
        S_BYTE: begin
          if (accept) begin
            csum <= csum ^ out_data;
            if (byte_sel != 2'd3) begin
              byte_sel <= next_sel;
              out_data <= next_byte;
            end else if (idx == LAST_IDX) begin
              state    <= S_CSUM;
              out_data <= csum ^ out_data;
            end else begin
              idx       <= idx + 1'b1;
              rd_addr   <= idx + 1'b1;
              out_valid <= 1'b0;
              state     <= S_LOAD;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
